i2c_config_sequencer: RTL and testbench

Parametrised I2C write sequencer that programs a peripheral codec (WM8731-class) by sending NUM_WORDS register writes over a single-master, open-drain I2C bus. It sits between the top-level control FSM and the codec I2C pins and replaces the fixed-table initializer. It adds a programmable bus clock divider, a captured per-run command table, ACK checking with bounded retry, and error reporting.

---
 rtl/i2c_config_sequencer.sv | 269 ++++++++++++++++++++++++++
 tb/tb_i2c_config_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_config_sequencer.sv
// Purpose: I2C write sequencer that programs a codec with NUM_WORDS captured 16-bit register writes.
// Latency: 120*NUM_WORDS*CLK_DIV + 2 cycles from accepted start to o_finished (more if any word is retried).
// Backpressure: i_start is accepted only from IDLE; requests while busy or during DONE are dropped.
module i2c_config_sequencer #(
    parameter int          NUM_WORDS = 7,
    parameter logic [6:0]  DEV_ADDR  = 7'h1A,
    parameter int          CLK_DIV   = 1,
    parameter int          MAX_RETRY = 3,
    parameter bit          CHECK_ACK = 1'b1
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_start,
    input  logic [16*NUM_WORDS-1:0]            i_words,
    output logic                               o_busy,
    output logic                               o_finished,
    output logic                               o_error,
    output logic [$clog2(NUM_WORDS+1)-1:0]     o_err_index,
    output logic                               o_sclk,
    inout  wire                                io_sdat,
    output logic                               o_oen
);

    localparam int WW = $clog2(NUM_WORDS + 1);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [WW-1:0] WORD_END  = WW'(NUM_WORDS);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_ACK,
        S_STOP,
        S_GAP,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [1:0]      qtr_q, qtr_d;
    logic [3:0]      bit_q, bit_d;       // 0..7 data bits, 8 = ACK slot
    logic [1:0]      byte_q, byte_d;     // byte within the frame, 0..2
    logic [WW-1:0]   word_q, word_d;     // word being sent; NUM_WORDS once all are done
    logic [RW-1:0]   retry_q, retry_d;
    logic            nack_q, nack_d;
    logic [15:0]     table_q [NUM_WORDS];
    logic [15:0]     table_d [NUM_WORDS];
    logic            busy_q, busy_d;
    logic            finished_q, finished_d;
    logic            error_q, error_d;
    logic [WW-1:0]   err_index_q, err_index_d;
    logic            sclk_q, sclk_d;
    logic            sdat_q, sdat_d;
    logic            oen_q, oen_d;

    logic            tick;
    logic            slot_end;
    logic [15:0]     cur_word;
    logic [23:0]     frame;
    logic [4:0]      bit_pos;

    // Quarter-bit tick: the divider only runs while a bus slot is in progress.
    assign tick     = (state_q != S_IDLE) && (state_q != S_DONE) && (div_q == DIV_LAST);
    assign slot_end = tick && (qtr_q == 2'd3);

    // Sequencing: divider, quarter/bit/byte/word counters, ACK checking and retry decisions.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        qtr_d       = qtr_q;
        bit_d       = bit_q;
        byte_d      = byte_q;
        word_d      = word_q;
        retry_d     = retry_q;
        nack_d      = nack_q;
        table_d     = table_q;
        busy_d      = busy_q;
        finished_d  = finished_q;
        error_d     = error_q;
        err_index_d = err_index_q;

        if ((state_q == S_IDLE) || (state_q == S_DONE) || tick) begin
            div_d = '0;
        end else begin
            div_d = div_q + DW'(1);
        end

        if (tick) begin
            qtr_d = qtr_q + 2'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    // The table is frozen here so the caller may change i_words mid-run.
                    for (int k = 0; k < NUM_WORDS; k++) begin
                        table_d[k] = i_words[16*k +: 16];
                    end
                    state_d     = S_START;
                    qtr_d       = 2'd0;
                    word_d      = '0;
                    retry_d     = '0;
                    nack_d      = 1'b0;
                    busy_d      = 1'b1;
                    finished_d  = 1'b0;
                    error_d     = 1'b0;
                    err_index_d = '0;
                end
            end
            S_START: begin
                if (slot_end) begin
                    state_d = S_BIT;
                    bit_d   = 4'd0;
                    byte_d  = 2'd0;
                end
            end
            S_BIT: begin
                if (slot_end) begin
                    bit_d = bit_q + 4'd1;
                    if (bit_q == 4'd7) begin
                        state_d = S_ACK;
                    end
                end
            end
            S_ACK: begin
                // The slave has had SCL high for a full quarter by the end of Q2.
                if (tick && (qtr_q == 2'd2)) begin
                    nack_d = io_sdat;
                end
                if (slot_end) begin
                    if (CHECK_ACK && nack_q) begin
                        // Abandon the rest of the frame; STOP then either retry or give up.
                        state_d = S_STOP;
                        if (retry_q == RETRY_MAX) begin
                            error_d     = 1'b1;
                            err_index_d = word_q;
                        end else begin
                            retry_d = retry_q + RW'(1);
                        end
                    end else if (byte_q == 2'd2) begin
                        state_d = S_STOP;
                        word_d  = word_q + WW'(1);
                        retry_d = '0;
                    end else begin
                        state_d = S_BIT;
                        byte_d  = byte_q + 2'd1;
                        bit_d   = 4'd0;
                    end
                end
            end
            S_STOP: begin
                if (slot_end) begin
                    state_d = error_q ? S_DONE : S_GAP;
                end
            end
            S_GAP: begin
                if (slot_end) begin
                    state_d = (word_q == WORD_END) ? S_DONE : S_START;
                end
            end
            S_DONE: begin
                state_d    = S_IDLE;
                busy_d     = 1'b0;
                finished_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus waveform for the slot/quarter being entered, so the pins are registered and glitch-free.
    always_comb begin
        cur_word = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (word_d == WW'(k)) begin
                cur_word = table_q[k];
            end
        end
        // byte1 = {reg[6:0], data[8]} and byte2 = data[7:0] are simply the word's two halves.
        frame   = {DEV_ADDR, 1'b0, cur_word};
        bit_pos = 5'd23 - {1'b0, byte_d, bit_d[2:0]};

        sclk_d = 1'b1;
        sdat_d = 1'b1;
        oen_d  = 1'b0;
        case (state_d)
            S_START: begin
                sclk_d = 1'b1;
                sdat_d = (qtr_d < 2'd2);
                oen_d  = 1'b1;
            end
            S_BIT: begin
                sclk_d = (qtr_d >= 2'd2);
                sdat_d = frame[bit_pos];
                oen_d  = 1'b1;
            end
            S_ACK: begin
                sclk_d = (qtr_d >= 2'd2);
                sdat_d = 1'b1;
                oen_d  = 1'b0;
            end
            S_STOP: begin
                sclk_d = (qtr_d >= 2'd2);
                sdat_d = (qtr_d == 2'd3);
                oen_d  = 1'b1;
            end
            default: begin
                sclk_d = 1'b1;
                sdat_d = 1'b1;
                oen_d  = 1'b0;
            end
        endcase
    end

    // All state and outputs; reset releases SDA immediately without a STOP.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            qtr_q       <= 2'd0;
            bit_q       <= 4'd0;
            byte_q      <= 2'd0;
            word_q      <= '0;
            retry_q     <= '0;
            nack_q      <= 1'b0;
            for (int k = 0; k < NUM_WORDS; k++) begin
                table_q[k] <= '0;
            end
            busy_q      <= 1'b0;
            finished_q  <= 1'b0;
            error_q     <= 1'b0;
            err_index_q <= '0;
            sclk_q      <= 1'b1;
            sdat_q      <= 1'b1;
            oen_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            qtr_q       <= qtr_d;
            bit_q       <= bit_d;
            byte_q      <= byte_d;
            word_q      <= word_d;
            retry_q     <= retry_d;
            nack_q      <= nack_d;
            table_q     <= table_d;
            busy_q      <= busy_d;
            finished_q  <= finished_d;
            error_q     <= error_d;
            err_index_q <= err_index_d;
            sclk_q      <= sclk_d;
            sdat_q      <= sdat_d;
            oen_q       <= oen_d;
        end
    end

    assign o_busy      = busy_q;
    assign o_finished  = finished_q;
    assign o_error     = error_q;
    assign o_err_index = err_index_q;
    assign o_sclk      = sclk_q;
    assign o_oen       = oen_q;
    assign io_sdat     = oen_q ? sdat_q : 1'bz;

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Bench for i2c_config_sequencer: a slot-level protocol model builds the expected per-cycle bus waveform.
// Latency: each run is compared cycle by cycle from acceptance through o_finished.
// Backpressure: exercises ignored starts while busy and in the DONE cycle.
module tb_i2c_config_sequencer;

    localparam int NW = 7;
    localparam int CD = 4;
    localparam int MR = 3;

    localparam int K_START = 0;
    localparam int K_BIT   = 1;
    localparam int K_ACK   = 2;
    localparam int K_STOP  = 3;
    localparam int K_GAP   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [16*NW-1:0]  words;
    logic              busy, fin, err, sclk, oen;
    logic [2:0]        eidx;
    wire               sda;
    logic              slave_low;

    // Pull-up plus an open-drain slave that can pull SDA low while the master has released it.
    assign sda = oen ? 1'bz : (slave_low ? 1'b0 : 1'b1);

    always #5 clk = ~clk;

    i2c_config_sequencer #(
        .NUM_WORDS (NW),
        .DEV_ADDR  (7'h1A),
        .CLK_DIV   (CD),
        .MAX_RETRY (MR),
        .CHECK_ACK (1'b1)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_words     (words),
        .o_busy      (busy),
        .o_finished  (fin),
        .o_error     (err),
        .o_err_index (eidx),
        .o_sclk      (sclk),
        .io_sdat     (sda),
        .o_oen       (oen)
    );

    typedef struct packed {
        logic scl;
        logic sda;
        logic oen;
        logic busy;
        logic fin;
        logic ack_low;
    } ent_t;

    int          n_vec = 0;
    int          n_bad = 0;
    ent_t        exp_q[$];
    logic        mon_bits[$];
    logic [15:0] tbl [NW];
    int          nk_w, nk_b, nk_n;
    logic        m_err;
    int          m_idx;
    int          bc;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, expv);
        end
    endtask

    // One bus slot = 4 quarters of CD cycles each, waveform straight from the slot definitions.
    function automatic void push_slot(input int kind, input logic b, input logic ackl);
        ent_t e;
        for (int q = 0; q < 4; q++) begin
            for (int c = 0; c < CD; c++) begin
                e = '0;
                e.busy = 1'b1;
                case (kind)
                    K_START: begin e.scl = 1'b1;     e.sda = (q < 2);  e.oen = 1'b1; end
                    K_BIT:   begin e.scl = (q >= 2); e.sda = b;        e.oen = 1'b1; end
                    K_ACK:   begin e.scl = (q >= 2); e.sda = 1'b1;     e.oen = 1'b0; e.ack_low = ackl; end
                    K_STOP:  begin e.scl = (q >= 2); e.sda = (q == 3); e.oen = 1'b1; end
                    default: begin e.scl = 1'b1;     e.sda = 1'b1;     e.oen = 1'b0; end
                endcase
                exp_q.push_back(e);
            end
        end
    endfunction

    // Whole-run model: frames per word, slave NACK plan, retries, then DONE and the finished cycle.
    function automatic void build_model();
        logic [23:0] frame;
        logic        nacked, nk;
        ent_t        e;
        exp_q.delete();
        m_err = 1'b0;
        m_idx = 0;
        for (int w = 0; w < NW; w++) begin
            frame = {7'h1A, 1'b0, tbl[w]};
            for (int a = 0; a <= MR; a++) begin
                push_slot(K_START, 1'b1, 1'b0);
                nacked = 1'b0;
                for (int b = 0; b < 3; b++) begin
                    for (int i = 0; i < 8; i++) push_slot(K_BIT, frame[23 - (b*8 + i)], 1'b0);
                    nk = (w == nk_w) && (b == nk_b) && (a < nk_n);
                    push_slot(K_ACK, 1'b1, !nk);
                    if (nk) begin
                        nacked = 1'b1;
                        break;
                    end
                end
                push_slot(K_STOP, 1'b0, 1'b0);
                if (nacked && (a == MR)) begin
                    m_err = 1'b1;
                    m_idx = w;
                    break;
                end
                push_slot(K_GAP, 1'b1, 1'b0);
                if (!nacked) break;
            end
            if (m_err) break;
        end
        e = '0; e.scl = 1'b1; e.sda = 1'b1; e.busy = 1'b1;
        exp_q.push_back(e);
        e = '0; e.scl = 1'b1; e.sda = 1'b1; e.fin = 1'b1;
        exp_q.push_back(e);
    endfunction

    // Start a run and compare every cycle; abort_at >= 0 hits reset at that cycle instead.
    task automatic run(input int abort_at, input bit done_poke, output int busy_cycles);
        ent_t e;
        logic prev_scl;
        int   n;
        build_model();
        n = exp_q.size();
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < NW; k++) words[16*k +: 16] = tbl[k];
        @(negedge clk);
        start = 1'b0;
        busy_cycles = 1;
        prev_scl = 1'b1;
        mon_bits.delete();
        for (int j = 0; j < n; j++) begin
            e = exp_q[j];
            if (j == abort_at) begin
                rst = 1'b1;
                #1;
                check("reset_mid_run {busy,oen,scl}", {29'd0, busy, oen, sclk}, 32'b001);
                @(negedge clk);
                rst = 1'b0;
                slave_low = 1'b0;
                return;
            end
            check($sformatf("cycle %0d {scl,oen,busy,fin,sda}", j),
                  {27'd0, sclk, oen, busy, fin, (e.oen ? sda : 1'b0)},
                  {27'd0, e.scl, e.oen, e.busy, e.fin, (e.oen ? e.sda : 1'b0)});
            if (busy) busy_cycles++;
            if (!prev_scl && sclk && oen) mon_bits.push_back(sda);
            prev_scl = sclk;
            if (j == n - 1) begin
                check("final {error,err_index}", {28'd0, err, eidx}, {28'd0, m_err, 3'(m_idx)});
            end
            slave_low = e.ack_low;
            start = 1'b0;
            if (j < n - 1) begin
                if ($urandom_range(0, 299) == 0) start = 1'b1;
                if (done_poke && (j == n - 2)) start = 1'b1;
                if ($urandom_range(0, 399) == 0) begin
                    for (int k = 0; k < NW; k++) words[16*k +: 16] = 16'($urandom);
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        slave_low = 1'b0;
        check("idle_after_done {busy,fin}", {30'd0, busy, fin}, 32'b01);
    endtask

    task automatic rand_table();
        for (int k = 0; k < NW; k++) tbl[k] = 16'($urandom);
    endtask

    initial begin
        logic [7:0] by;
        rst = 1'b1;
        start = 1'b0;
        words = '0;
        slave_low = 1'b0;
        nk_w = -1; nk_b = 0; nk_n = 0;
        repeat (3) @(negedge clk);
        check("reset busy",      {31'd0, busy}, 32'd0);
        check("reset finished",  {31'd0, fin},  32'd0);
        check("reset error",     {31'd0, err},  32'd0);
        check("reset err_index", {29'd0, eidx}, 32'd0);
        check("reset sclk",      {31'd0, sclk}, 32'd1);
        check("reset oen",       {31'd0, oen},  32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Clean run of a WM8731-style table, with a start poked during DONE.
        tbl = '{16'h1E00, 16'h0C10, 16'h0E42, 16'h0812, 16'h0A00, 16'h1001, 16'h1201};
        run(-1, 1'b1, bc);
        check("model length clean run", exp_q.size(), 32'd3362);
        check("busy span clean run", bc, 32'd3362);
        for (int f = 0; f < 3; f++) begin
            by = '0;
            for (int i = 0; i < 8; i++) by = {by[6:0], mon_bits[f*8 + i]};
            check($sformatf("word0 byte%0d", f), {24'd0, by}, (f == 0) ? 32'h34 : (f == 1) ? 32'h1E : 32'h00);
        end

        // Word 2 NACKed once in byte1, then accepted.
        rand_table();
        nk_w = 2; nk_b = 1; nk_n = 1;
        run(-1, 1'b0, bc);
        check("model length one retry", exp_q.size(), 32'd3698);

        // Word 3 always NACKed in byte2: four attempts then error.
        rand_table();
        nk_w = 3; nk_b = 2; nk_n = 99;
        run(-1, 1'b0, bc);
        check("model length exhausted", exp_q.size(), 32'd3346);
        check("error flag", {31'd0, err}, 32'd1);
        check("error index", {29'd0, eidx}, 32'd3);

        // Reset during byte1 of word 0, then a full clean rerun.
        rand_table();
        nk_w = -1; nk_n = 0;
        run(50 * CD, 1'b0, bc);
        run(-1, 1'b0, bc);

        // Randomised NACK plans.
        for (int r = 0; r < 4; r++) begin
            rand_table();
            nk_w = $urandom_range(0, NW - 1);
            nk_b = $urandom_range(0, 2);
            nk_n = $urandom_range(0, MR + 1);
            run(-1, ($urandom_range(0, 1) == 1), bc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
